cpu_mem_axi_bridge: RTL and testbench

Converts the custom CPU's single-outstanding, valid/ready data-memory request interface into single-beat AXI4 transactions on the `cpu_mem_*` AR/R/AW/W/B channels consumed by the 2x1 CPU-to-memory AXI arbiter. It sits directly upstream of that arbiter on the data side. It latches each request, issues exactly one AXI transaction, and returns read data through a held valid/ready response. One transaction is in flight at a time.

---
 rtl/cpu_mem_axi_bridge_if.sv | 58 +++++
 rtl/cpu_mem_axi_bridge.sv | 148 ++++++++++++++
 tb/tb_cpu_mem_axi_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_axi_bridge_if.sv
// AXI4 single-beat channel bundle between the CPU data-memory bridge and the
// CPU-to-memory arbiter; master = bridge side, slave = memory/arbiter side.
`timescale 1ns/1ps
interface cpu_mem_axi_bridge_if;
  logic [31:0] cpu_mem_araddr;
  logic        cpu_mem_arvalid;
  logic        cpu_mem_arready;
  logic [2:0]  cpu_mem_arsize;
  logic [1:0]  cpu_mem_arburst;
  logic [7:0]  cpu_mem_arlen;

  logic [31:0] cpu_mem_rdata;
  logic        cpu_mem_rvalid;
  logic        cpu_mem_rready;
  logic        cpu_mem_rlast;

  logic [31:0] cpu_mem_awaddr;
  logic        cpu_mem_awvalid;
  logic        cpu_mem_awready;
  logic [2:0]  cpu_mem_awsize;
  logic [1:0]  cpu_mem_awburst;
  logic [7:0]  cpu_mem_awlen;

  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_wvalid;
  logic        cpu_mem_wready;
  logic        cpu_mem_wlast;

  logic        cpu_mem_bvalid;
  logic        cpu_mem_bready;

  modport master (
    output cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arsize, cpu_mem_arburst, cpu_mem_arlen,
    input  cpu_mem_arready,
    input  cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
    output cpu_mem_rready,
    output cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awsize, cpu_mem_awburst, cpu_mem_awlen,
    input  cpu_mem_awready,
    output cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast,
    input  cpu_mem_wready,
    input  cpu_mem_bvalid,
    output cpu_mem_bready
  );

  modport slave (
    input  cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arsize, cpu_mem_arburst, cpu_mem_arlen,
    output cpu_mem_arready,
    output cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
    input  cpu_mem_rready,
    input  cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awsize, cpu_mem_awburst, cpu_mem_awlen,
    output cpu_mem_awready,
    input  cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast,
    output cpu_mem_wready,
    output cpu_mem_bvalid,
    input  cpu_mem_bready
  );
endinterface

// File: rtl/cpu_mem_axi_bridge.sv
// CPU data-memory request to single-beat AXI4 bridge, one transaction in flight.
// Optional performance counters are enabled by defining MEM_BRIDGE_PERF_CNT_EN.
`timescale 1ns/1ps
module cpu_mem_axi_bridge #(
  parameter int unsigned ADDR_ALIGN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  cpu_mem_axi_bridge_if.master axi
`ifdef MEM_BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_busy_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_RESP, WR_REQ, WR_B} state_t;

  state_t      state_q, state_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqData_q, reqData_d;
  logic [3:0]  reqStrb_q, reqStrb_d;
  logic [31:0] readData_q, readData_d;
  logic        awDone_q, awDone_d;
  logic        wDone_q, wDone_d;
  logic [31:0] axiAddr;
  logic        unusedRlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      reqAddr_q  <= '0;
      reqData_q  <= '0;
      reqStrb_q  <= '0;
      readData_q <= '0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reqAddr_q  <= reqAddr_d;
      reqData_q  <= reqData_d;
      reqStrb_q  <= reqStrb_d;
      readData_q <= readData_d;
      awDone_q   <= awDone_d;
      wDone_q    <= wDone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reqAddr_d  = reqAddr_q;
    reqData_d  = reqData_q;
    reqStrb_d  = reqStrb_q;
    readData_d = readData_q;
    awDone_d   = awDone_q;
    wDone_d    = wDone_q;
    case (state_q)
      IDLE: begin
        awDone_d = 1'b0;
        wDone_d  = 1'b0;
        if (MemWrite) begin
          reqAddr_d = Address;
          reqData_d = Write_data;
          reqStrb_d = Write_strb;
          state_d   = WR_REQ;
        end else if (MemRead) begin
          reqAddr_d = Address;
          state_d   = RD_AR;
        end
      end
      RD_AR: if (axi.cpu_mem_arready) state_d = RD_R;
      RD_R: begin
        if (axi.cpu_mem_rvalid) begin
          readData_d = axi.cpu_mem_rdata;
          state_d    = RD_RESP;
        end
      end
      RD_RESP: if (Read_data_Ready) state_d = IDLE;
      WR_REQ: begin
        // AW and W complete independently; leave only once both have handshaken.
        if (axi.cpu_mem_awready) awDone_d = 1'b1;
        if (axi.cpu_mem_wready)  wDone_d  = 1'b1;
        if (awDone_d && wDone_d) state_d = WR_B;
      end
      WR_B: if (axi.cpu_mem_bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign axiAddr = (ADDR_ALIGN != 0) ? {reqAddr_q[31:2], 2'b00} : reqAddr_q;

  assign Mem_Req_Ready   = (state_q == IDLE);
  assign Read_data_Valid = (state_q == RD_RESP);
  assign Read_data       = readData_q;

  assign axi.cpu_mem_araddr  = axiAddr;
  assign axi.cpu_mem_arvalid = (state_q == RD_AR);
  assign axi.cpu_mem_arsize  = 3'b010;
  assign axi.cpu_mem_arburst = 2'b01;
  assign axi.cpu_mem_arlen   = 8'd0;
  assign axi.cpu_mem_rready  = (state_q == RD_R);

  assign axi.cpu_mem_awaddr  = axiAddr;
  assign axi.cpu_mem_awvalid = (state_q == WR_REQ) && !awDone_q;
  assign axi.cpu_mem_awsize  = 3'b010;
  assign axi.cpu_mem_awburst = 2'b01;
  assign axi.cpu_mem_awlen   = 8'd0;

  assign axi.cpu_mem_wdata   = reqData_q;
  assign axi.cpu_mem_wstrb   = reqStrb_q;
  assign axi.cpu_mem_wvalid  = (state_q == WR_REQ) && !wDone_q;
  assign axi.cpu_mem_wlast   = axi.cpu_mem_wvalid;
  assign axi.cpu_mem_bready  = (state_q == WR_B);

  // Single-beat reads always end on the first R beat, so rlast carries no information.
  assign unusedRlast = axi.cpu_mem_rlast;

`ifdef MEM_BRIDGE_PERF_CNT_EN
  logic [31:0] perfRdCnt_q, perfWrCnt_q, perfBusyCnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfRdCnt_q   <= '0;
      perfWrCnt_q   <= '0;
      perfBusyCnt_q <= '0;
    end else begin
      if (axi.cpu_mem_rvalid && axi.cpu_mem_rready) perfRdCnt_q <= perfRdCnt_q + 32'd1;
      if (axi.cpu_mem_bvalid && axi.cpu_mem_bready) perfWrCnt_q <= perfWrCnt_q + 32'd1;
      if (state_q != IDLE) perfBusyCnt_q <= perfBusyCnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt   = perfRdCnt_q;
  assign perf_wr_cnt   = perfWrCnt_q;
  assign perf_busy_cnt = perfBusyCnt_q;
`endif

endmodule

// File: tb/tb_cpu_mem_axi_bridge.sv
// Directed testbench for cpu_mem_axi_bridge; checks counters too when
// MEM_BRIDGE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_cpu_mem_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
`ifdef MEM_BRIDGE_PERF_CNT_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_busy_cnt;
`endif

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  cpu_mem_axi_bridge_if axi();

  cpu_mem_axi_bridge #(.ADDR_ALIGN(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .axi             (axi.master)
`ifdef MEM_BRIDGE_PERF_CNT_EN
    ,
    .perf_rd_cnt     (perf_rd_cnt),
    .perf_wr_cnt     (perf_wr_cnt),
    .perf_busy_cnt   (perf_busy_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = data;
    Write_strb = strb;
  endtask

  task automatic zeroWaitRead(input string tag, input logic [31:0] addr,
                              input logic [31:0] expAddr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0);
    checkOutput({tag, " req_ready"}, {31'b0, Mem_Req_Ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput({tag, " araddr"}, axi.cpu_mem_araddr, expAddr);
    axi.cpu_mem_arready = 1'b1;
    tick();
    axi.cpu_mem_arready = 1'b0;
    axi.cpu_mem_rvalid  = 1'b1;
    axi.cpu_mem_rdata   = data;
    tick();
    axi.cpu_mem_rvalid  = 1'b0;
    checkOutput({tag, " rdata"}, Read_data, data);
    Read_data_Ready = 1'b1;
    tick();
    Read_data_Ready = 1'b0;
    checkOutput({tag, " idle"}, {31'b0, Mem_Req_Ready}, 32'd1);
  endtask

  task automatic zeroWaitWrite(input string tag, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    applyStimulus(1'b0, 1'b1, addr, data, strb);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput({tag, " awaddr"}, axi.cpu_mem_awaddr, addr);
    checkOutput({tag, " wdata"}, axi.cpu_mem_wdata, data);
    axi.cpu_mem_awready = 1'b1;
    axi.cpu_mem_wready  = 1'b1;
    tick();
    axi.cpu_mem_awready = 1'b0;
    axi.cpu_mem_wready  = 1'b0;
    checkOutput({tag, " bready"}, {31'b0, axi.cpu_mem_bready}, 32'd1);
    axi.cpu_mem_bvalid  = 1'b1;
    tick();
    axi.cpu_mem_bvalid  = 1'b0;
    checkOutput({tag, " idle"}, {31'b0, Mem_Req_Ready}, 32'd1);
  endtask

  initial begin
    axi.cpu_mem_arready = 1'b0;
    axi.cpu_mem_rdata   = '0;
    axi.cpu_mem_rvalid  = 1'b0;
    axi.cpu_mem_rlast   = 1'b1;
    axi.cpu_mem_awready = 1'b0;
    axi.cpu_mem_wready  = 1'b0;
    axi.cpu_mem_bvalid  = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("rst arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);
    checkOutput("rst rready", {31'b0, axi.cpu_mem_rready}, 32'd0);
    checkOutput("rst awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd0);
    checkOutput("rst wvalid", {31'b0, axi.cpu_mem_wvalid}, 32'd0);
    checkOutput("rst bready", {31'b0, axi.cpu_mem_bready}, 32'd0);
    checkOutput("rst rd_valid", {31'b0, Read_data_Valid}, 32'd0);
    checkOutput("rst rd_data", Read_data, 32'h0);
    checkOutput("rst araddr", axi.cpu_mem_araddr, 32'h0);
    checkOutput("rst wstrb", {28'b0, axi.cpu_mem_wstrb}, 32'h0);
    resetn = 1'b1;
    tick();

    // Read, zero wait
    $display("[TB] read zero-wait");
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    checkOutput("rd0 c0 req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rd0 c1 arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd1);
    checkOutput("rd0 c1 araddr", axi.cpu_mem_araddr, 32'h0000_1004);
    checkOutput("rd0 c1 arlen", {24'b0, axi.cpu_mem_arlen}, 32'd0);
    checkOutput("rd0 c1 arsize", {29'b0, axi.cpu_mem_arsize}, 32'd2);
    checkOutput("rd0 c1 arburst", {30'b0, axi.cpu_mem_arburst}, 32'd1);
    checkOutput("rd0 c1 req_ready", {31'b0, Mem_Req_Ready}, 32'd0);
    axi.cpu_mem_arready = 1'b1;
    tick();
    axi.cpu_mem_arready = 1'b0;
    checkOutput("rd0 c2 arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);
    checkOutput("rd0 c2 rready", {31'b0, axi.cpu_mem_rready}, 32'd1);
    axi.cpu_mem_rvalid = 1'b1;
    axi.cpu_mem_rdata  = 32'hDEAD_BEEF;
    tick();
    axi.cpu_mem_rvalid = 1'b0;
    axi.cpu_mem_rdata  = 32'h0;
    checkOutput("rd0 c3 rd_valid", {31'b0, Read_data_Valid}, 32'd1);
    checkOutput("rd0 c3 rd_data", Read_data, 32'hDEAD_BEEF);
    checkOutput("rd0 c3 rready", {31'b0, axi.cpu_mem_rready}, 32'd0);
    Read_data_Ready = 1'b1;
    tick();
    Read_data_Ready = 1'b0;
    checkOutput("rd0 c4 req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("rd0 c4 rd_valid", {31'b0, Read_data_Valid}, 32'd0);
    checkOutput("rd0 c4 rd_data held", Read_data, 32'hDEAD_BEEF);

    // Read with AR and response backpressure
    $display("[TB] read backpressure");
    applyStimulus(1'b1, 1'b0, 32'h0000_2010, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd1 ar wait arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd1);
      checkOutput("rd1 ar wait araddr", axi.cpu_mem_araddr, 32'h0000_2010);
      checkOutput("rd1 ar wait req_ready", {31'b0, Mem_Req_Ready}, 32'd0);
      tick();
    end
    checkOutput("rd1 ar hs arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd1);
    axi.cpu_mem_arready = 1'b1;
    tick();
    axi.cpu_mem_arready = 1'b0;
    checkOutput("rd1 rready", {31'b0, axi.cpu_mem_rready}, 32'd1);
    axi.cpu_mem_rvalid = 1'b1;
    axi.cpu_mem_rdata  = 32'hCAFE_F00D;
    tick();
    axi.cpu_mem_rvalid = 1'b0;
    axi.cpu_mem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      checkOutput("rd1 resp hold valid", {31'b0, Read_data_Valid}, 32'd1);
      checkOutput("rd1 resp hold data", Read_data, 32'hCAFE_F00D);
      checkOutput("rd1 resp hold req_ready", {31'b0, Mem_Req_Ready}, 32'd0);
      tick();
    end
    Read_data_Ready = 1'b1;
    tick();
    Read_data_Ready = 1'b0;
    checkOutput("rd1 done req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("rd1 done rd_valid", {31'b0, Read_data_Valid}, 32'd0);

    // Write with split AW/W handshakes
    $display("[TB] write split handshakes");
    applyStimulus(1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 4'b0011);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr0 c1 awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd1);
    checkOutput("wr0 c1 wvalid", {31'b0, axi.cpu_mem_wvalid}, 32'd1);
    checkOutput("wr0 c1 wlast", {31'b0, axi.cpu_mem_wlast}, 32'd1);
    checkOutput("wr0 c1 awaddr", axi.cpu_mem_awaddr, 32'h0000_2008);
    checkOutput("wr0 c1 wdata", axi.cpu_mem_wdata, 32'h1234_5678);
    checkOutput("wr0 c1 wstrb", {28'b0, axi.cpu_mem_wstrb}, 32'h3);
    checkOutput("wr0 c1 awlen", {24'b0, axi.cpu_mem_awlen}, 32'd0);
    checkOutput("wr0 c1 awsize", {29'b0, axi.cpu_mem_awsize}, 32'd2);
    checkOutput("wr0 c1 awburst", {30'b0, axi.cpu_mem_awburst}, 32'd1);
    axi.cpu_mem_wready = 1'b1;
    tick();
    axi.cpu_mem_wready = 1'b0;
    checkOutput("wr0 c2 wvalid", {31'b0, axi.cpu_mem_wvalid}, 32'd0);
    checkOutput("wr0 c2 wlast", {31'b0, axi.cpu_mem_wlast}, 32'd0);
    checkOutput("wr0 c2 awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd1);
    tick();
    checkOutput("wr0 c3 awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd1);
    checkOutput("wr0 c3 awaddr", axi.cpu_mem_awaddr, 32'h0000_2008);
    checkOutput("wr0 c3 bready", {31'b0, axi.cpu_mem_bready}, 32'd0);
    axi.cpu_mem_awready = 1'b1;
    tick();
    axi.cpu_mem_awready = 1'b0;
    checkOutput("wr0 c4 awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd0);
    checkOutput("wr0 c4 bready", {31'b0, axi.cpu_mem_bready}, 32'd1);
    checkOutput("wr0 c4 req_ready", {31'b0, Mem_Req_Ready}, 32'd0);
    tick();
    checkOutput("wr0 c5 bready", {31'b0, axi.cpu_mem_bready}, 32'd1);
    axi.cpu_mem_bvalid = 1'b1;
    tick();
    axi.cpu_mem_bvalid = 1'b0;
    checkOutput("wr0 c6 req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("wr0 c6 bready", {31'b0, axi.cpu_mem_bready}, 32'd0);

    // Write priority over read, address alignment
    $display("[TB] priority and alignment");
    applyStimulus(1'b1, 1'b1, 32'h0000_3003, 32'hA5A5_5A5A, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("pri c1 awvalid", {31'b0, axi.cpu_mem_awvalid}, 32'd1);
    checkOutput("pri c1 awaddr", axi.cpu_mem_awaddr, 32'h0000_3000);
    checkOutput("pri c1 arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);
    checkOutput("pri c1 wstrb", {28'b0, axi.cpu_mem_wstrb}, 32'hF);
    axi.cpu_mem_awready = 1'b1;
    axi.cpu_mem_wready  = 1'b1;
    tick();
    axi.cpu_mem_awready = 1'b0;
    axi.cpu_mem_wready  = 1'b0;
    checkOutput("pri c2 bready", {31'b0, axi.cpu_mem_bready}, 32'd1);
    checkOutput("pri c2 arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);
    axi.cpu_mem_bvalid = 1'b1;
    tick();
    axi.cpu_mem_bvalid = 1'b0;
    checkOutput("pri c3 req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("pri c3 arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);

    // Asynchronous reset while waiting for R
    $display("[TB] async reset mid-read");
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axi.cpu_mem_arready = 1'b1;
    tick();
    axi.cpu_mem_arready = 1'b0;
    checkOutput("arst pre rready", {31'b0, axi.cpu_mem_rready}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst rready", {31'b0, axi.cpu_mem_rready}, 32'd0);
    checkOutput("arst req_ready", {31'b0, Mem_Req_Ready}, 32'd1);
    checkOutput("arst rd_data", Read_data, 32'h0);
    checkOutput("arst araddr", axi.cpu_mem_araddr, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checkOutput("arst released arvalid", {31'b0, axi.cpu_mem_arvalid}, 32'd0);

    // Two reads and one write back to back (also feeds the counters)
    $display("[TB] back-to-back transactions");
    zeroWaitRead("rdA", 32'h0000_5008, 32'h0000_5008, 32'h0BAD_F00D);
    zeroWaitRead("rdB", 32'h0000_500E, 32'h0000_500C, 32'h7654_3210);
    zeroWaitWrite("wrA", 32'h0000_6004, 32'h0F0F_F0F0, 4'b1100);
`ifdef MEM_BRIDGE_PERF_CNT_EN
    checkOutput("perf_rd_cnt", perf_rd_cnt, 32'd2);
    checkOutput("perf_wr_cnt", perf_wr_cnt, 32'd1);
    checkOutput("perf_busy_cnt", perf_busy_cnt, 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
